cache_tag_judge: RTL and testbench

//  Tag store and hit/miss judge for the 4-way, 16-line, 64-byte/line PSRAM cache (4 KiB).

---
 rtl/cache_tag_judge.sv | 207 ++++++++++++++++++++
 tb/tb_cache_tag_judge.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_judge.sv
`default_nettype none
// ============================================================================
// Module  : cache_tag_judge
// Brief   : 4-way tag store, PLRU victim select and hit/miss judge for the
//           16-line PSRAM cache, with a one-line-per-cycle invalidate sweep.
// Revision: 1.0 - initial release
// ============================================================================
module cache_tag_judge #(
   parameter int LINE_NUM      = 16,
   parameter int TAG_W         = 13,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic             cpuclk,
   input  logic             WSHRST,
   input  logic             init_req,
   output logic             run_inittag,
   input  logic             READ_TAG,
   input  logic [3:0]       read_lineno,
   input  logic [22:0]      buf_addr,
   input  logic             buf_wvalid,
   input  logic             buf_rvalid,
   output logic [3:0]       HIT_way,
   output logic             MISS,
   output logic [3:0]       miss_way,
   output logic             miss_dirty,
   output logic [TAG_W-1:0] miss_tag,
   output logic [3:0]       miss_lineno,
   output logic [TAG_W-1:0] refill_tag,
   input  logic             fill_done,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_CMP   = 2'd2,
      ST_MWAIT = 2'd3
   } state_t;

   localparam logic [3:0] c_LAST_LINE = 4'(LINE_NUM - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_valid [LINE_NUM];
   logic [3:0]       r_dirty [LINE_NUM];
   logic [2:0]       r_plru  [LINE_NUM];
   logic [TAG_W-1:0] r_tag   [LINE_NUM][4];
   logic [3:0]       r_init_cnt;
   logic             r_init_pend;
   logic [3:0]       r_cmp_line;
   logic [TAG_W-1:0] r_cmp_tag;
   logic             r_cmp_wr;
   logic [3:0]       w_cur_valid;
   logic [2:0]       w_cur_plru;
   logic [3:0]       w_hit_vec;
   logic [3:0]       w_vict;
   logic [TAG_W-1:0] w_vict_tag;
   logic             w_unused;

   // A read is the default; only the write flag changes behaviour.
   assign w_unused    = ^{buf_rvalid, buf_addr[9:0]};
   assign run_inittag = (r_state == ST_INIT);
   assign busy        = (r_state != ST_IDLE);

   assign w_cur_valid  = r_valid[r_cmp_line];
   assign w_cur_plru   = r_plru[r_cmp_line];
   assign w_hit_vec[0] = w_cur_valid[0] && (r_tag[r_cmp_line][0] == r_cmp_tag);
   assign w_hit_vec[1] = w_cur_valid[1] && (r_tag[r_cmp_line][1] == r_cmp_tag);
   assign w_hit_vec[2] = w_cur_valid[2] && (r_tag[r_cmp_line][2] == r_cmp_tag);
   assign w_hit_vec[3] = w_cur_valid[3] && (r_tag[r_cmp_line][3] == r_cmp_tag);

   // PLRU bits: [0]=pair select, [1]=within {0,1}, [2]=within {2,3}.
   function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [3:0] way);
      logic [2:0] n;
      n = p;
      if (way[0]) begin
         n[0] = 1'b1; n[1] = 1'b1;
      end else if (way[1]) begin
         n[0] = 1'b1; n[1] = 1'b0;
      end else if (way[2]) begin
         n[0] = 1'b0; n[2] = 1'b1;
      end else if (way[3]) begin
         n[0] = 1'b0; n[2] = 1'b0;
      end
      return n;
   endfunction

   always_comb begin
      w_vict = 4'b0001;
      if (!w_cur_valid[0])      w_vict = 4'b0001;
      else if (!w_cur_valid[1]) w_vict = 4'b0010;
      else if (!w_cur_valid[2]) w_vict = 4'b0100;
      else if (!w_cur_valid[3]) w_vict = 4'b1000;
      else if (!w_cur_plru[0])  w_vict = w_cur_plru[1] ? 4'b0010 : 4'b0001;
      else                      w_vict = w_cur_plru[2] ? 4'b1000 : 4'b0100;
   end

   always_comb begin
      w_vict_tag = r_tag[r_cmp_line][0];
      case (w_vict)
         4'b0010: w_vict_tag = r_tag[r_cmp_line][1];
         4'b0100: w_vict_tag = r_tag[r_cmp_line][2];
         4'b1000: w_vict_tag = r_tag[r_cmp_line][3];
         default: w_vict_tag = r_tag[r_cmp_line][0];
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_INIT:  if (r_init_cnt == c_LAST_LINE) w_state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (init_req || r_init_pend) w_state_nxt = ST_INIT;
            else if (READ_TAG)           w_state_nxt = ST_CMP;
         end
         ST_CMP:   w_state_nxt = (|w_hit_vec) ? ST_IDLE : ST_MWAIT;
         ST_MWAIT: if (fill_done) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge cpuclk or posedge WSHRST) begin
      if (WSHRST) r_state <= INIT_ON_RESET ? ST_INIT : ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge cpuclk or posedge WSHRST) begin
      if (WSHRST) begin
         for (int l = 0; l < LINE_NUM; l++) begin
            r_valid[l]  <= '0;
            r_dirty[l]  <= '0;
            r_plru[l]   <= '0;
            r_tag[l][0] <= '0;
            r_tag[l][1] <= '0;
            r_tag[l][2] <= '0;
            r_tag[l][3] <= '0;
         end
         r_init_cnt  <= '0;
         r_init_pend <= 1'b0;
         r_cmp_line  <= '0;
         r_cmp_tag   <= '0;
         r_cmp_wr    <= 1'b0;
         HIT_way     <= '0;
         MISS        <= 1'b0;
         miss_way    <= '0;
         miss_dirty  <= 1'b0;
         miss_tag    <= '0;
         miss_lineno <= '0;
         refill_tag  <= '0;
      end else begin
         HIT_way <= '0;
         MISS    <= 1'b0;
         // An init request seen while busy is remembered until the next IDLE cycle.
         if (r_state == ST_IDLE) r_init_pend <= 1'b0;
         else if (init_req)      r_init_pend <= 1'b1;

         case (r_state)
            ST_INIT: begin
               r_valid[r_init_cnt] <= '0;
               r_dirty[r_init_cnt] <= '0;
               r_plru[r_init_cnt]  <= '0;
               r_init_cnt <= (r_init_cnt == c_LAST_LINE) ? 4'd0 : r_init_cnt + 4'd1;
            end
            ST_IDLE: begin
               if (w_state_nxt == ST_CMP) begin
                  r_cmp_line <= read_lineno;
                  r_cmp_tag  <= buf_addr[22 -: TAG_W];
                  r_cmp_wr   <= buf_wvalid;
               end
            end
            ST_CMP: begin
               if (|w_hit_vec) begin
                  HIT_way            <= w_hit_vec;
                  r_plru[r_cmp_line] <= plru_touch(w_cur_plru, w_hit_vec);
                  if (r_cmp_wr) r_dirty[r_cmp_line] <= r_dirty[r_cmp_line] | w_hit_vec;
               end else begin
                  MISS        <= 1'b1;
                  miss_way    <= w_vict;
                  miss_dirty  <= |(w_vict & w_cur_valid & r_dirty[r_cmp_line]);
                  miss_tag    <= w_vict_tag;
                  miss_lineno <= r_cmp_line;
                  refill_tag  <= r_cmp_tag;
               end
            end
            ST_MWAIT: begin
               if (fill_done) begin
                  r_valid[miss_lineno] <= r_valid[miss_lineno] | miss_way;
                  r_dirty[miss_lineno] <= r_dirty[miss_lineno] & ~miss_way;
                  r_plru[miss_lineno]  <= plru_touch(r_plru[miss_lineno], miss_way);
                  if (miss_way[0]) r_tag[miss_lineno][0] <= refill_tag;
                  if (miss_way[1]) r_tag[miss_lineno][1] <= refill_tag;
                  if (miss_way[2]) r_tag[miss_lineno][2] <= refill_tag;
                  if (miss_way[3]) r_tag[miss_lineno][3] <= refill_tag;
                  miss_way   <= '0;
                  miss_dirty <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   a_onehot_hit: assert property (@(posedge cpuclk) disable iff (WSHRST)
      (r_state == ST_CMP) |-> $onehot0(w_hit_vec));

endmodule
`default_nettype wire

// File: tb/tb_cache_tag_judge.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_tag_judge
// Brief   : Directed and randomized checks of cache_tag_judge against a
//           per-line/per-way reference model of the tag store.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_tag_judge;

   logic        cpuclk;
   logic        WSHRST;
   logic        init_req;
   logic        run_inittag;
   logic        READ_TAG;
   logic [3:0]  read_lineno;
   logic [22:0] buf_addr;
   logic        buf_wvalid;
   logic        buf_rvalid;
   logic [3:0]  HIT_way;
   logic        MISS;
   logic [3:0]  miss_way;
   logic        miss_dirty;
   logic [12:0] miss_tag;
   logic [3:0]  miss_lineno;
   logic [12:0] refill_tag;
   logic        fill_done;
   logic        busy;

   cache_tag_judge dut (
      .cpuclk(cpuclk), .WSHRST(WSHRST), .init_req(init_req), .run_inittag(run_inittag),
      .READ_TAG(READ_TAG), .read_lineno(read_lineno), .buf_addr(buf_addr),
      .buf_wvalid(buf_wvalid), .buf_rvalid(buf_rvalid), .HIT_way(HIT_way), .MISS(MISS),
      .miss_way(miss_way), .miss_dirty(miss_dirty), .miss_tag(miss_tag),
      .miss_lineno(miss_lineno), .refill_tag(refill_tag), .fill_done(fill_done), .busy(busy)
   );

   initial begin
      cpuclk = 1'b0;
      forever #5 cpuclk = ~cpuclk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: contents of each line/way, plus the three PLRU bits b0,b1,b2.
   bit          m_valid [16][4];
   bit          m_dirty [16][4];
   logic [12:0] m_tag   [16][4];
   bit          m_b0 [16];
   bit          m_b1 [16];
   bit          m_b2 [16];

   bit          g_miss;
   int          g_vline, g_vway;
   logic [12:0] g_vtag;
   logic [3:0]  g_hitway, g_missway;
   logic        g_missdirty;
   logic [12:0] g_misstag;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void m_clear();
      for (int l = 0; l < 16; l++) begin
         for (int w = 0; w < 4; w++) begin
            m_valid[l][w] = 1'b0;
            m_dirty[l][w] = 1'b0;
         end
         m_b0[l] = 1'b0; m_b1[l] = 1'b0; m_b2[l] = 1'b0;
      end
   endfunction

   function automatic int m_lookup(input int l, input logic [12:0] t);
      for (int w = 0; w < 4; w++)
         if (m_valid[l][w] && m_tag[l][w] == t) return w;
      return -1;
   endfunction

   function automatic int m_victim(input int l);
      for (int w = 0; w < 4; w++)
         if (!m_valid[l][w]) return w;
      if (!m_b0[l]) return m_b1[l] ? 1 : 0;
      return m_b2[l] ? 3 : 2;
   endfunction

   function automatic void m_touch(input int l, input int w);
      case (w)
         0: begin m_b0[l] = 1'b1; m_b1[l] = 1'b1; end
         1: begin m_b0[l] = 1'b1; m_b1[l] = 1'b0; end
         2: begin m_b0[l] = 1'b0; m_b2[l] = 1'b1; end
         default: begin m_b0[l] = 1'b0; m_b2[l] = 1'b0; end
      endcase
   endfunction

   function automatic logic [22:0] mk(input int t, input int l);
      return {t[12:0], l[3:0], 6'd0};
   endfunction

   // Present one READ_TAG in IDLE and check the result two cycles later.
   task automatic issue(input logic [22:0] addr, input bit wr, input bit rv);
      int l, w, v;
      logic [12:0] t;
      l = int'(addr[9:6]);
      t = addr[22:10];
      w = m_lookup(l, t);
      buf_addr = addr; read_lineno = addr[9:6]; buf_wvalid = wr; buf_rvalid = rv;
      READ_TAG = 1'b1;
      @(posedge cpuclk); #1;
      READ_TAG = 1'b0;
      chk("latency_t1", {27'd0, HIT_way, MISS}, 32'd0);
      @(posedge cpuclk); #1;
      g_hitway = HIT_way; g_missway = miss_way; g_missdirty = miss_dirty; g_misstag = miss_tag;
      if (w >= 0) begin
         g_miss = 1'b0;
         chk("hit_way", HIT_way, 32'd1 << w);
         chk("hit_nomiss", MISS, 32'd0);
         m_touch(l, w);
         if (wr) m_dirty[l][w] = 1'b1;
      end else begin
         g_miss = 1'b1;
         v = m_victim(l);
         chk("miss_pulse", MISS, 32'd1);
         chk("miss_nohit", HIT_way, 32'd0);
         chk("miss_way", miss_way, 32'd1 << v);
         chk("miss_dirty", miss_dirty, {31'd0, m_valid[l][v] && m_dirty[l][v]});
         chk("miss_lineno", miss_lineno, l);
         chk("refill_tag", refill_tag, t);
         if (m_valid[l][v]) chk("miss_tag", miss_tag, m_tag[l][v]);
         g_vline = l; g_vway = v; g_vtag = t;
      end
   endtask

   // Hold MWAIT for dly cycles (optionally poking init_req / READ_TAG), then fill.
   task automatic fill(input int dly, input bit inj_init, input bit inj_rt);
      for (int i = 0; i < dly; i++) begin
         if (i == 0) begin
            init_req = inj_init;
            READ_TAG = inj_rt;
            buf_addr = 23'($urandom);
            read_lineno = buf_addr[9:6];
         end
         @(posedge cpuclk); #1;
         init_req = 1'b0; READ_TAG = 1'b0;
         chk("wait_busy", busy, 32'd1);
         chk("wait_missway", miss_way, 32'd1 << g_vway);
         chk("wait_nopulse", {27'd0, HIT_way, MISS}, 32'd0);
         chk("wait_noinit", run_inittag, 32'd0);
      end
      fill_done = 1'b1;
      @(posedge cpuclk); #1;
      fill_done = 1'b0;
      chk("fill_idle", busy, 32'd0);
      m_valid[g_vline][g_vway] = 1'b1;
      m_dirty[g_vline][g_vway] = 1'b0;
      m_tag[g_vline][g_vway]   = g_vtag;
      m_touch(g_vline, g_vway);
   endtask

   // Called while the sweep is expected to be running; counts its length.
   task automatic sweep(input int exp_n);
      int n;
      bit pulse;
      n = 0; pulse = 1'b0;
      while (run_inittag && n < 200) begin
         if (HIT_way != 4'd0 || MISS) pulse = 1'b1;
         @(posedge cpuclk); #1;
         n++;
      end
      if (HIT_way != 4'd0 || MISS) pulse = 1'b1;
      chk("sweep_len", n, exp_n);
      chk("sweep_nopulse", {31'd0, pulse}, 32'd0);
      chk("sweep_busy", busy, 32'd0);
      m_clear();
   endtask

   int lsel[4] = '{0, 1, 14, 15};

   initial begin
      WSHRST = 1'b1; init_req = 1'b0; READ_TAG = 1'b0; read_lineno = '0;
      buf_addr = '0; buf_wvalid = 1'b0; buf_rvalid = 1'b0; fill_done = 1'b0;
      m_clear();
      for (int l = 0; l < 16; l++)
         for (int w = 0; w < 4; w++) m_tag[l][w] = '0;

      // Reset state and the automatic sweep.
      repeat (3) @(posedge cpuclk);
      #1;
      chk("rst_run_inittag", run_inittag, 32'd1);
      chk("rst_busy", busy, 32'd1);
      chk("rst_pulses", {27'd0, HIT_way, MISS}, 32'd0);
      chk("rst_miss_info", {miss_way, miss_dirty, miss_tag, refill_tag}, 32'd0);
      @(negedge cpuclk);
      WSHRST = 1'b0;
      sweep(16);

      // First miss on an empty cache, then the re-issued access hits.
      issue(23'h000040, 1'b0, 1'b1);
      chk("t2_missway", g_missway, 32'b0001);
      chk("t2_missdirty", g_missdirty, 32'd0);
      chk("t2_lineno", miss_lineno, 32'd1);
      chk("t2_refill", refill_tag, 32'd0);
      fill(2, 1'b0, 1'b0);
      issue(23'h000040, 1'b0, 1'b1);
      chk("t2_hit", g_hitway, 32'b0001);

      // Explicit invalidate from IDLE.
      init_req = 1'b1;
      @(posedge cpuclk); #1;
      init_req = 1'b0;
      sweep(16);

      // Dirty victim selection on line 1.
      for (int t = 1; t <= 4; t++) begin
         issue(mk(t, 1), 1'b0, 1'b1);
         fill(1, 1'b0, 1'b0);
      end
      issue(mk(2, 1), 1'b1, 1'b0);
      chk("t3_wr_hit", g_hitway, 32'b0010);
      issue(mk(1, 1), 1'b0, 1'b1);
      issue(mk(3, 1), 1'b0, 1'b1);
      issue(mk(4, 1), 1'b0, 1'b1);
      issue(mk(5, 1), 1'b0, 1'b1);
      chk("t3_victim", g_missway, 32'b0010);
      chk("t3_dirty", g_missdirty, 32'd1);
      chk("t3_tag", g_misstag, 32'd2);
      fill(0, 1'b0, 1'b0);

      // PLRU ordering on line 3.
      for (int t = 1; t <= 4; t++) begin
         issue(mk(t, 3), 1'b0, 1'b1);
         fill(0, 1'b0, 1'b0);
      end
      for (int t = 1; t <= 4; t++) issue(mk(t, 3), 1'b0, 1'b0);
      issue(mk(9, 3), 1'b0, 1'b1);
      chk("t4_victim0", g_missway, 32'b0001);
      fill(1, 1'b0, 1'b0);
      issue(mk(9, 3), 1'b0, 1'b1);
      chk("t4_hit0", g_hitway, 32'b0001);
      issue(mk(10, 3), 1'b0, 1'b1);
      chk("t4_victim2", g_missway, 32'b0100);
      fill(2, 1'b0, 1'b0);

      // init_req held pending during MWAIT; READ_TAG there is ignored.
      issue(mk(7, 5), 1'b0, 1'b1);
      fill(3, 1'b1, 1'b1);
      @(posedge cpuclk); #1;
      sweep(16);
      issue(mk(2, 1), 1'b0, 1'b1);
      chk("t5_miss_l1", {31'd0, g_miss}, 32'd1);
      fill(0, 1'b0, 1'b0);
      issue(mk(9, 3), 1'b0, 1'b1);
      chk("t5_miss_l3", {31'd0, g_miss}, 32'd1);
      fill(0, 1'b0, 1'b0);

      // READ_TAG and init_req together: INIT wins, no result pulse.
      buf_addr = mk(9, 3); read_lineno = 4'd3; buf_wvalid = 1'b0; buf_rvalid = 1'b1;
      READ_TAG = 1'b1; init_req = 1'b1;
      @(posedge cpuclk); #1;
      READ_TAG = 1'b0; init_req = 1'b0;
      sweep(16);
      issue(mk(9, 3), 1'b0, 1'b1);
      chk("t6_miss_after", {31'd0, g_miss}, 32'd1);
      fill(1, 1'b0, 1'b0);

      // Reset in the middle of MWAIT.
      issue(mk(6, 15), 1'b1, 1'b0);
      #2 WSHRST = 1'b1;
      #1;
      chk("rstmw_init", run_inittag, 32'd1);
      chk("rstmw_missway", miss_way, 32'd0);
      @(posedge cpuclk); #2;
      WSHRST = 1'b0;
      sweep(16);
      issue(mk(9, 3), 1'b0, 1'b1);
      chk("rstmw_miss", {31'd0, g_miss}, 32'd1);
      fill(1, 1'b0, 1'b0);

      // Randomized traffic over a few heavily shared lines.
      for (int k = 0; k < 250; k++) begin : rnd
         logic [22:0] a;
         bit wr, rv, inj;
         int l, t, dly, sel;
         sel = $urandom_range(0, 7);
         l = (sel < 4) ? lsel[sel] : $urandom_range(0, 15);
         t = $urandom_range(0, 5);
         a = mk(t, l) | 23'($urandom_range(0, 63));
         wr = ($urandom_range(0, 2) == 0);
         rv = wr ? 1'b0 : ($urandom_range(0, 3) != 0);
         issue(a, wr, rv);
         if (g_miss) begin
            inj = ($urandom_range(0, 19) == 0);
            dly = $urandom_range(inj ? 1 : 0, 3);
            fill(dly, inj, $urandom_range(0, 3) == 0);
            if (inj) begin
               @(posedge cpuclk); #1;
               sweep(16);
            end else begin
               issue(a, wr, rv);
            end
         end
         if ($urandom_range(0, 9) == 0) begin
            fill_done = 1'b1;
            @(posedge cpuclk); #1;
            fill_done = 1'b0;
            chk("stray_fill_idle", busy, 32'd0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
